// File: rtl/symbol_sequencer.sv
// Symbol message buffer with timed playback feeding the seven-segment decoder select input.
// Optional build macro SYMBOL_SEQUENCER_LOOP_EN: wrap playback to the first symbol instead of stopping.
module symbol_sequencer #(
  parameter int          DEPTH = 8,
  parameter int          HOLD  = 4,
  parameter logic [5:0]  BLANK = 6'd63
) (
  input  logic                       clk_2,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [5:0]                 wr_code,
  input  logic                       play,
  input  logic                       clear,
  output logic [5:0]                 code_out,
  output logic                       playing,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t          state, state_nxt;
  logic [5:0]      mem [DEPTH];
  logic [IW-1:0]   idx, idx_nxt;
  logic [HW-1:0]   hold, hold_nxt;
  logic [CW-1:0]   count_nxt;
  logic            play_d;
  logic            play_edge;
  logic            wr_accept;
  logic [5:0]      code_nxt;
  logic            playing_nxt;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign play_edge = play & ~play_d;

  // State register; code_out and playing are registered from the next-state view
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      hold     <= '0;
      count    <= '0;
      play_d   <= 1'b0;
      code_out <= BLANK;
      playing  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      hold     <= hold_nxt;
      count    <= count_nxt;
      play_d   <= play;
      code_out <= code_nxt;
      playing  <= playing_nxt;
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset_n && wr_accept)
      mem[count[IW-1:0]] <= wr_code;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hold_nxt  = hold;
    count_nxt = count;
    wr_accept = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      idx_nxt   = '0;
      hold_nxt  = '0;
    end else if (play_edge) begin
      // A play edge always consumes the cycle, so a coincident write is dropped
      if (!empty) begin
        state_nxt = PLAY;
        idx_nxt   = '0;
        hold_nxt  = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (wr_en && !full) begin
            wr_accept = 1'b1;
            count_nxt = count + CW'(1);
          end
        end
        PLAY: begin
          if (hold == HOLD_LAST) begin
            hold_nxt = '0;
            if (({1'b0, idx} + CW'(1)) < count) begin
              idx_nxt = idx + IW'(1);
            end else begin
`ifdef SYMBOL_SEQUENCER_LOOP_EN
              idx_nxt = '0;
`else
              idx_nxt   = '0;
              state_nxt = IDLE;
`endif
            end
          end else begin
            hold_nxt = hold + HW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    playing_nxt = (state_nxt == PLAY);
    code_nxt    = playing_nxt ? mem[idx_nxt] : BLANK;
  end

endmodule

// File: tb/tb_symbol_sequencer.sv
// Self-checking bench for symbol_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_symbol_sequencer;
  localparam int DEPTH = 8;
  localparam int HOLD  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_2 = 1'b0;
  logic          reset_n, wr_en, play, clear;
  logic [5:0]    wr_code;
  logic [5:0]    code_out;
  logic          playing, full, empty;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  // Model: message as a queue, playback as elapsed cycles since start
  logic [5:0] mq[$];
  bit         m_active = 0;
  int         m_t = 0;
  bit         m_play_prev = 0;

  symbol_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD), .BLANK(6'd63)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .wr_en(wr_en), .wr_code(wr_code),
    .play(play), .clear(clear), .code_out(code_out), .playing(playing),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit clr, input bit pl, input bit wr, input logic [5:0] code);
    if (!rst) begin
      mq.delete(); m_active = 0; m_t = 0;
    end else if (clr) begin
      mq.delete(); m_active = 0;
    end else if (pl && !m_play_prev) begin
      if (mq.size() > 0) begin m_active = 1; m_t = 0; end
    end else if (m_active) begin
      m_t++;
      if (m_t == mq.size() * HOLD) begin
`ifdef SYMBOL_SEQUENCER_LOOP_EN
        m_t = 0;
`else
        m_active = 0;
`endif
      end
    end else if (wr && mq.size() < DEPTH) begin
      mq.push_back(code);
    end
    m_play_prev = rst ? pl : 1'b0;
  endtask

  task automatic step(input bit rst, input bit clr, input bit pl, input bit wr, input logic [5:0] code);
    int exp_code;
    reset_n = rst; clear = clr; play = pl; wr_en = wr; wr_code = code;
    @(posedge clk_2);
    model_step(rst, clr, pl, wr, code);
    #1;
    exp_code = m_active ? int'(mq[m_t / HOLD]) : 63;
    check("code_out", int'(code_out), exp_code);
    check("playing", int'(playing), int'(m_active));
    check("count", int'(count), mq.size());
    check("full", int'(full), int'(mq.size() == DEPTH));
    check("empty", int'(empty), int'(mq.size() == 0));
  endtask

  initial begin
    bit pl_lvl;
    logic [5:0] demo[3];
    demo[0] = 6'd10; demo[1] = 6'd11; demo[2] = 6'd12;
    reset_n = 1'b0; clear = 1'b0; play = 1'b0; wr_en = 1'b0; wr_code = '0;

    // Reset for two cycles
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_code", int'(code_out), 63);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);

    // A, b, C message with single-play timing
    for (int unsigned i = 0; i < 3; i++) step(1, 0, 0, 1, demo[i]);
    step(1, 0, 1, 0, 0);
    check("abc_first", int'(code_out), 10);
    for (int unsigned i = 1; i < 12; i++) begin
      step(1, 0, 1, 0, 0);
      check("abc_seq", int'(code_out), int'(demo[i / HOLD]));
    end
    step(1, 0, 0, 0, 0);
`ifndef SYMBOL_SEQUENCER_LOOP_EN
    check("abc_end_code", int'(code_out), 63);
    check("abc_end_playing", int'(playing), 0);
`endif
    check("abc_count", int'(count), 3);

    // Overfill then play 0..7
    step(1, 1, 0, 0, 0);
    for (int unsigned i = 0; i < 9; i++) begin
      step(1, 0, 0, 1, 6'(i));
      if (i == 7) check("full_after_8", int'(full), 1);
    end
    check("count_after_9", int'(count), 8);
    step(1, 0, 1, 0, 0);
    for (int unsigned i = 0; i < 33; i++) step(1, 0, (i < 3), 0, 0);

    // Empty play edge, then 5/41 build, write during play, clear mid-symbol
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    check("empty_play_code", int'(code_out), 63);
    check("empty_play_playing", int'(playing), 0);
    step(1, 0, 0, 1, 6'd5);
    step(1, 0, 0, 1, 6'd41);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 6'd7);
    check("wr_in_play_count", int'(count), 2);
    for (int unsigned i = 0; i < 25; i++) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check("clear_code", int'(code_out), 63);
    check("clear_count", int'(count), 0);
    check("clear_playing", int'(playing), 0);

    // Clear beats write; later play edge on empty ignored
    step(1, 0, 0, 1, 6'd1);
    step(1, 0, 0, 1, 6'd2);
    step(1, 1, 0, 1, 6'd3);
    check("clr_wr_count", int'(count), 0);
    step(1, 0, 1, 0, 0);
    check("clr_wr_play_code", int'(code_out), 63);

    // Random traffic
    pl_lvl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 14) == 0) pl_lvl = ~pl_lvl;
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 59) == 0), pl_lvl,
           ($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/symbol_sequencer.md
# symbol_sequencer

Upstream feeder for the board's seven-segment symbol decoder: stores a short message of 6-bit symbol codes (0–9 digits, 10–41 letters/degree sign, as accepted by the decoder) and plays it back one symbol at a time at a fixed hold interval. Sits between the switch inputs (SWI) and the decoder's 6-bit select input, replacing the direct SWI[5:0] connection. Its code output is fully registered, so the decoder stays purely combinational.

## Interface
- DEPTH, 8: message buffer entries; power of two, 2..16.
- HOLD, 4: clk_2 cycles each symbol is held during playback; ≥1.
- BLANK, 6'd63: code driven when nothing is shown; decodes to all segments off.

- clk_2  in  1  the only clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  append wr_code to the buffer this cycle.
- wr_code  in  6  symbol code to append.
- play  in  1  level; a 0→1 transition starts playback.
- clear  in  1  empty the buffer and abort playback.
- code_out  out  6  current symbol code to the decoder.
- playing  out  1  high while in PLAY.
- count  out  $clog2(DEPTH)+1  number of stored symbols.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Buffer: DEPTH×6 registers, write pointer equal to count. A write stores wr_code at index count; count then increments.
- Priority each cycle: reset_n low > clear > play edge > wr_en.
- States: IDLE, PLAY.
  - IDLE: code_out = BLANK, playing = 0. wr_en accepted if !full; ignored when full (count, full unchanged). A play rising edge with count > 0 moves to PLAY with idx = 0 and hold = 0. A play edge while empty is ignored.
  - PLAY: code_out = buf[idx], playing = 1. hold counts 0..HOLD-1. At hold == HOLD-1: if idx < count-1, then idx+1 and hold = 0; else end-of-message (see Configuration). wr_en is ignored. A further play edge restarts from idx 0 with hold 0.
- clear: count = 0, empty = 1, full = 0, state IDLE, code_out = BLANK next cycle. Buffer contents are not zeroed.
- Play-edge detection uses a registered copy of play, reset to 0. If play is held high through reset, this registered copy starts playback one cycle after reset release only when count > 0, which is never true straight out of reset.
- Codes 42–63 are stored and played verbatim; the decoder shows them blank.

## Timing
- Reset values: code_out = BLANK, playing = 0, count = 0, empty = 1, full = 0, state IDLE, idx = 0, hold = 0, play delay register = 0.
- Write: count, full and empty update in the cycle after the wr_en edge.
- Play: play rises at cycle N. Cycle N+1 shows buf[0] with playing = 1. Each symbol lasts exactly HOLD cycles.
- Total non-loop playback: count×HOLD cycles with playing = 1. BLANK and playing = 0 follow on the next cycle.
- clear or reset mid-playback: code_out = BLANK in the following cycle. No partial hold is completed.
- Simultaneous clear and wr_en: clear wins and the write is dropped. Simultaneous play edge and wr_en in IDLE: play wins and the write is dropped.

## Configuration
- SYMBOL_SEQUENCER_LOOP_EN defined: at end of message, idx wraps to 0 and playback continues indefinitely. Playback leaves PLAY only via clear or reset.
- Not defined: at end of message, return to IDLE; code_out = BLANK, playing = 0. Buffer contents and count are retained, so a new play edge replays the message.

## Test plan
- Reset with reset_n = 0 for 2 cycles: code_out = 63, count = 0, empty = 1, full = 0, playing = 0.
- Write 10, 11, 12 (A, b, C), then a play edge with HOLD = 4, no loop: code_out = 10 for 4 cycles, then 11 ×4, then 12 ×4, then 63 with playing = 0. count stays 3.
- Write 9 codes with DEPTH = 8: full = 1 after the 8th write, and the 9th write is ignored (count = 8). Playback shows codes 0..7 in order.
- Loop build: 2 codes (5, 41), play, observe 5 ×4, 41 ×4, 5 ×4 … for ≥3 passes. Assert clear mid-symbol: next cycle code_out = 63, count = 0, playing = 0.
- Play edge with empty buffer: stays IDLE, code_out = 63. wr_en during PLAY: count unchanged.
- Simultaneous clear + wr_en (code 3) with count = 2: count = 0 afterwards, and a subsequent play edge is ignored.
